// File: rtl/awb_gain_scheduler.sv
// AWB gain scheduler: one shared restoring divider produces green/red, green/green and
// green/blue gains (x256 fixed point), published together once per frame.
module awb_gain_scheduler #(
  parameter int                MEAN_W   = 32,
  parameter int                GAIN_W   = 24,
  parameter logic [GAIN_W-1:0] GAIN_MAX = GAIN_W'(1023),
  parameter logic [GAIN_W-1:0] GAIN_MIN = GAIN_W'(64)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vsync,
  input  logic [MEAN_W-1:0] mean_R,
  input  logic [MEAN_W-1:0] mean_G,
  input  logic [MEAN_W-1:0] mean_B,
  output logic [GAIN_W-1:0] gain_R,
  output logic [GAIN_W-1:0] gain_G,
  output logic [GAIN_W-1:0] gain_B,
  output logic              gain_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int                CNT_W = $clog2(GAIN_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(GAIN_W - 1);
  localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(256);

  typedef enum logic [2:0] {IDLE, LATCH, DIV_R, DIV_G, DIV_B, COMMIT} state_t;

  state_t                  st_q, st_d;
  logic                    vsync_q, trig;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [16:0]             rem_q, rem_d;
  logic [GAIN_W-1:0]       quo_q, quo_d;
  logic [GAIN_W-1:0]       dvd_q, dvd_d;
  logic [2:0][15:0]        dvs_q, dvs_d;
  logic [2:0][GAIN_W-1:0]  shd_q, shd_d;
  logic [2:0][GAIN_W-1:0]  gain_q, gain_d;
  logic                    gv_q, gv_d, ovr_q, ovr_d;

  logic [1:0]        ch;
  logic [15:0]       dvs_sel;
  logic              dvd_bit;
  logic [16:0]       trial;
  logic              ge;
  logic [GAIN_W-1:0] q_next, q_cond;

  assign trig = vsync & ~vsync_q;

  // Divider datapath, shared by the three division states.
  always_comb begin
    ch = 2'd0;
    case (st_q)
      DIV_G:   ch = 2'd1;
      DIV_B:   ch = 2'd2;
      default: ch = 2'd0;
    endcase
    dvs_sel = dvs_q[ch];
    dvd_bit = dvd_q[LAST - cnt_q];
    trial   = {rem_q[15:0], dvd_bit};
    ge      = (trial >= {1'b0, dvs_sel});
    q_next  = {quo_q[GAIN_W-2:0], ge};
    if (dvs_sel == 16'd0)       q_cond = GAIN_MAX;
    else if (q_next > GAIN_MAX) q_cond = GAIN_MAX;
    else if (q_next < GAIN_MIN) q_cond = GAIN_MIN;
    else                        q_cond = q_next;
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    shd_d  = shd_q;
    gain_d = gain_q;
    gv_d   = 1'b0;
    ovr_d  = trig && (st_q != IDLE);
    case (st_q)
      IDLE: if (trig) st_d = LATCH;
      LATCH: begin
        dvd_d    = GAIN_W'({mean_G[MEAN_W-1 -: 16], 8'd0});
        dvs_d[0] = mean_R[MEAN_W-1 -: 16];
        dvs_d[1] = mean_G[MEAN_W-1 -: 16];
        dvs_d[2] = mean_B[MEAN_W-1 -: 16];
        rem_d    = '0;
        quo_d    = '0;
        cnt_d    = '0;
        st_d     = DIV_R;
      end
      DIV_R, DIV_G, DIV_B: begin
        rem_d = ge ? (trial - {1'b0, dvs_sel}) : trial;
        quo_d = q_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Final quotient bit: condition and park in the shadow, clear for the next channel.
          shd_d[ch] = q_cond;
          rem_d     = '0;
          quo_d     = '0;
          cnt_d     = '0;
          case (st_q)
            DIV_R:   st_d = DIV_G;
            DIV_G:   st_d = DIV_B;
            default: st_d = COMMIT;
          endcase
        end
      end
      COMMIT: begin
        gain_d = shd_q;
        gv_d   = 1'b1;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= IDLE;
      vsync_q <= 1'b0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      shd_q   <= {3{UNITY}};
      gain_q  <= {3{UNITY}};
      gv_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      vsync_q <= vsync;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      shd_q   <= shd_d;
      gain_q  <= gain_d;
      gv_q    <= gv_d;
      ovr_q   <= ovr_d;
    end
  end

  assign gain_R     = gain_q[0];
  assign gain_G     = gain_q[1];
  assign gain_B     = gain_q[2];
  assign gain_valid = gv_q;
  assign overrun    = ovr_q;
  assign busy       = (st_q != IDLE);

endmodule

// File: tb/tb_awb_gain_scheduler.sv
// Bench for awb_gain_scheduler: frame-timeline reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_awb_gain_scheduler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vsync = 1'b0;
  logic [31:0] mean_R = '0, mean_G = '0, mean_B = '0;
  logic [23:0] gain_R, gain_G, gain_B;
  logic        gain_valid, busy, overrun;

  int errors = 0;
  int checks = 0;

  awb_gain_scheduler dut (
    .clk(clk), .reset(reset), .vsync(vsync),
    .mean_R(mean_R), .mean_G(mean_G), .mean_B(mean_B),
    .gain_R(gain_R), .gain_G(gain_G), .gain_B(gain_B),
    .gain_valid(gain_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int gain_of(input int num, input int den);
    int q;
    if (den == 0) return 1023;
    q = (num * 256) / den;
    if (q > 1023) return 1023;
    if (q < 64) return 64;
    return q;
  endfunction

  // Reference model: phase = cycles since the accepted trigger (0 = idle, 1..74 busy).
  bit live = 0;
  int phase = 0;
  bit prev_vs = 0;
  int eg[3] = '{256, 256, 256};
  int pend[3] = '{256, 256, 256};
  bit egv = 0, eovr = 0;

  always @(negedge clk) begin
    bit t;
    if (live) begin
      chk("m_gain_R", gain_R, eg[0]);
      chk("m_gain_G", gain_G, eg[1]);
      chk("m_gain_B", gain_B, eg[2]);
      chk("m_valid", gain_valid, egv);
      chk("m_busy", busy, (phase >= 1 && phase <= 74));
      chk("m_overrun", overrun, eovr);
    end
    if (reset) begin
      live = 1; phase = 0; prev_vs = 0; egv = 0; eovr = 0;
      eg = '{256, 256, 256};
    end else if (live) begin
      t = vsync && !prev_vs;
      egv = (phase == 74);
      eovr = t && (phase != 0);
      if (phase == 74) eg = pend;
      if (phase == 1) begin
        pend[0] = gain_of(int'(mean_G[31:16]), int'(mean_R[31:16]));
        pend[1] = gain_of(int'(mean_G[31:16]), int'(mean_G[31:16]));
        pend[2] = gain_of(int'(mean_G[31:16]), int'(mean_B[31:16]));
      end
      if (phase == 0) phase = t ? 1 : 0;
      else if (phase == 74) phase = 0;
      else phase = phase + 1;
      prev_vs = vsync;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic set_means(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b);
    mean_R = {r, 16'($urandom)};
    mean_G = {g, 16'($urandom)};
    mean_B = {b, 16'($urandom)};
  endtask

  // Called at posedge+2 with vsync low; raises vsync (cycle 0) and waits for the publish.
  task automatic frame(input logic [15:0] r, input logic [15:0] g, input logic [15:0] b,
                       output int at);
    at = -1;
    set_means(r, g, b);
    vsync = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (c == 1)  chk("busy_c1", busy, 1);
      if (c == 74) chk("busy_c74", busy, 1);
      if (gain_valid && at < 0) at = c;
      #1;
      if (c == 2) vsync = 1'b0;
      if (at >= 0) break;
    end
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0: return 16'd0;
      1: return 16'($urandom_range(1, 32));
      2: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int at, seen;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_gain_R", gain_R, 256);
    chk("rst_gain_G", gain_G, 256);
    chk("rst_gain_B", gain_B, 256);
    chk("rst_busy", busy, 0);
    chk("rst_valid", gain_valid, 0);
    chk("rst_overrun", overrun, 0);
    repeat (2) tick();

    frame(16'd1024, 16'd1024, 16'd1024, at);
    chk("f1_latency", at, 75);
    chk("f1_R", gain_R, 256); chk("f1_G", gain_G, 256); chk("f1_B", gain_B, 256);
    tick();
    chk("f1_valid_1cyc", gain_valid, 0);

    frame(16'd512, 16'd1024, 16'd2048, at);
    chk("f2_latency", at, 75);
    chk("f2_R", gain_R, 512); chk("f2_G", gain_G, 256); chk("f2_B", gain_B, 128);
    tick();

    frame(16'd16, 16'd1024, 16'd0, at);
    chk("f3_latency", at, 75);
    chk("f3_R_clamp", gain_R, 1023); chk("f3_G", gain_G, 256); chk("f3_B_zero", gain_B, 1023);
    tick();

    frame(16'd65535, 16'd1024, 16'd1024, at);
    chk("f4_R_min", gain_R, 64); chk("f4_B", gain_B, 256);
    tick();

    // Overrun: second rise in cycle 30 with other means; first frame's gains must win.
    at = -1;
    set_means(16'd512, 16'd1024, 16'd2048);
    vsync = 1'b1;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (c == 31) chk("ovr_pulse", overrun, 1);
      if (c == 32) chk("ovr_1cyc", overrun, 0);
      if (gain_valid && at < 0) at = c;
      #1;
      if (c == 2)  vsync = 1'b0;
      if (c == 10) set_means(16'd100, 16'd200, 16'd300);
      if (c == 30) vsync = 1'b1;
      if (c == 33) vsync = 1'b0;
    end
    chk("ovr_latency", at, 75);
    chk("ovr_R", gain_R, 512); chk("ovr_G", gain_G, 256); chk("ovr_B", gain_B, 128);
    frame(16'd1024, 16'd1024, 16'd1024, at);
    chk("ovr_next_latency", at, 75);
    chk("ovr_next_R", gain_R, 256);
    tick();
    frame(16'd512, 16'd1024, 16'd2048, at);
    chk("pre_rst_R", gain_R, 512);
    tick();

    // Reset mid-computation in cycle 40.
    set_means(16'd2048, 16'd1024, 16'd512);
    vsync = 1'b1;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (gain_valid) seen++;
      #1;
      if (c == 2)  vsync = 1'b0;
      if (c == 40) reset = 1'b1;
    end
    @(posedge clk); #1;
    chk("mid_rst_R", gain_R, 256); chk("mid_rst_G", gain_G, 256); chk("mid_rst_B", gain_B, 256);
    chk("mid_rst_busy", busy, 0);
    #1; reset = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (gain_valid) seen++;
      #1;
    end
    chk("mid_rst_no_valid", seen, 0);
    frame(16'd512, 16'd1024, 16'd2048, at);
    chk("post_rst_latency", at, 75);
    chk("post_rst_R", gain_R, 512); chk("post_rst_B", gain_B, 128);
    tick();

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 4000; c++) begin
      set_means(rnd16(), rnd16(), rnd16());
      if ($urandom_range(0, 15) == 0) vsync = ~vsync;
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0;
    vsync = 1'b0;
    repeat (100) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/awb_gain_scheduler.md
Name: awb_gain_scheduler

Overview:
- Computes the per-frame white-balance gains gain_R, gain_G and gain_B from the accumulated channel means.
- Uses one shared iterative restoring divider, time-multiplexed across the three channels and sequenced by an FSM.
- Sits between the AWB frame-statistics accumulator and the pixel gain multipliers.
- New gains are published together in a single cycle, once per frame, so the multipliers never see a mix of old and new gains.

Parameters:
- MEAN_W, 32, width of each mean input; the divide uses bits [MEAN_W-1:MEAN_W-16].
- GAIN_W, 24, width of quotient and gain outputs; also the divider iteration count per channel.
- GAIN_MAX, 24'd1023, upper clamp on each gain (about 4.0 in x256 fixed point); also the result for a zero divisor.
- GAIN_MIN, 24'd64, lower clamp on each gain (0.25).

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- vsync  input  1  frame sync; its rising edge triggers one gain computation.
- mean_R  input  MEAN_W  red channel frame statistic.
- mean_G  input  MEAN_W  green channel frame statistic.
- mean_B  input  MEAN_W  blue channel frame statistic.
- gain_R  output  GAIN_W  red gain, x256 fixed point (256 = unity).
- gain_G  output  GAIN_W  green gain, x256 fixed point.
- gain_B  output  GAIN_W  blue gain, x256 fixed point.
- gain_valid  output  1  one-cycle pulse when new gains are published.
- busy  output  1  high while a computation is in progress.
- overrun  output  1  one-cycle pulse when a trigger arrives while busy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: gain_R = gain_G = gain_B = 256; gain_valid = 0; busy = 0; overrun = 0; FSM in IDLE; internal vsync_q = 0.
- Trigger: vsync_q is vsync registered one cycle. trig = vsync & ~vsync_q. The cycle in which trig is high is cycle 0.
- FSM states: IDLE, LATCH, DIV_R, DIV_G, DIV_B, COMMIT.
- IDLE: on trig, go to LATCH.
- LATCH (cycle 1):
  - Register dvd = {mean_G[MEAN_W-1:MEAN_W-16], 8'd0} (24 bits).
  - Register dR, dG, dB = the upper 16 bits of mean_R, mean_G, mean_B.
  - Inputs are not sampled again until the next trigger.
- DIV_R, DIV_G, DIV_B:
  - Each state lasts exactly GAIN_W cycles (cycles 2–25, 26–49 and 50–73 at the default width).
  - Restoring division, one quotient bit per cycle, MSB first, using a 17-bit partial remainder.
  - Per cycle: rem = {rem[15:0], dvd_bit}; if rem >= divisor, subtract the divisor and shift in q=1, else shift in q=0.
  - The remainder and quotient registers are cleared on entry to each division state.
  - An internal iteration counter counts 0 to GAIN_W-1 and wraps to 0 on each state change.
- Result conditioning, applied at the end of each division:
  - If the divisor is 0, the result is GAIN_MAX.
  - Otherwise the result is clamped to [GAIN_MIN, GAIN_MAX].
  - Conditioned results are held in shadow registers; the outputs do not change yet.
- COMMIT (cycle 74): copy all three shadow registers to gain_R/G/B simultaneously, then return to IDLE.
- Output timing:
  - The new gains and gain_valid = 1 are visible in cycle 75 (2 + 3*GAIN_W + 1 cycles after trigger); gain_valid is high for exactly one cycle.
  - busy = 1 from cycle 1 through cycle 74 inclusive, and 0 in IDLE.
- Trigger while busy:
  - A trig in any state other than IDLE is ignored and overrun pulses high in that same-edge-registered next cycle.
  - The computation in progress completes using its latched values.
- Trigger in the COMMIT cycle: ignored and flagged as overrun. The FSM returns to IDLE and the next trigger is accepted.
- Reset mid-operation: abandons the computation with no gain_valid; gains return to 256 on the next edge.
- Gains are held indefinitely between commits.
- The green gain is computed rather than forced, so a nonzero green divisor always yields exactly 256.

Test Plan:
- Reset held for 3 cycles, then released with vsync = 0 -> gains = 256/256/256, busy = 0, gain_valid = 0, overrun = 0.
- Upper 16 bits of mean_R/G/B = 1024/1024/1024, one vsync rise -> busy in cycles 1–74; gain_valid pulse in cycle 75 with gains 256/256/256.
- Upper 16 bits of mean_R/G/B = 512/1024/2048 -> gain_R = 512, gain_G = 256, gain_B = 128, all changing in the same cycle.
- Upper 16 bits of mean_R = 16 and mean_B = 0, mean_G = 1024 -> gain_R = 1023 (clamped from 16384), gain_B = 1023 (zero divisor). Upper 16 bits of mean_R = 65535 -> gain_R = 64 (clamped from 4).
- Second vsync rise in cycle 30 with different means -> overrun pulse; the first frame's gains are published in cycle 75; a third vsync after cycle 75 is accepted normally.
- Reset asserted in cycle 40, after a prior commit produced 512/256/128 -> gains = 256 after reset; no gain_valid; the next trigger gives a normal 75-cycle result.
